// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for the scalar and vector register files: stalls decode on
// RAW/WAW/FULL hazards for long-latency writes. Optional checker: define WB_SCOREBOARD_CHECK_EN.
module wb_scoreboard #(
    parameter int SREG_NUM        = 32,
    parameter int VREG_NUM        = 16,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CW             = $clog2(MAX_OUTSTANDING + 1),
    localparam int SAW            = $clog2(SREG_NUM),
    localparam int VAW            = $clog2(VREG_NUM)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           DE_issue,
    input  logic [SAW-1:0] DE_S1_address,
    input  logic [SAW-1:0] DE_S2_address,
    input  logic [VAW-1:0] DE_V1_address,
    input  logic [VAW-1:0] DE_V2_address,
    input  logic [3:0]     DE_src_used,
    input  logic           DE_Swb_en,
    input  logic [SAW-1:0] DE_Swb_address,
    input  logic           DE_Vwb_en,
    input  logic [VAW-1:0] DE_Vwb_address,
    input  logic           DE_long,
    input  logic           MEM_WB_long,
    input  logic           MEM_WB_Swb_en,
    input  logic [SAW-1:0] MEM_WB_Swb_address,
    input  logic           MEM_WB_Vwb_en,
    input  logic [VAW-1:0] MEM_WB_Vwb_address,
    output logic           DE_stall,
    output logic           DE_accept,
    output logic [CW-1:0]  outstanding,
`ifdef WB_SCOREBOARD_CHECK_EN
    output logic           sb_error,
`endif
    output logic           sb_idle
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [SREG_NUM-1:0] s_pend, s_clr, s_set, s_eff;
    logic [VREG_NUM-1:0] v_pend, v_clr, v_set, v_eff;
    logic                raw, waw, full, set_go, dec;
    logic [CW-1:0]       cnt_next;

    // Only long-latency completions clear pending bits; ALU results are forwarded.
    always_comb begin
        s_clr = '0;
        v_clr = '0;
        if (MEM_WB_long && MEM_WB_Swb_en) s_clr[MEM_WB_Swb_address] = 1'b1;
        if (MEM_WB_long && MEM_WB_Vwb_en) v_clr[MEM_WB_Vwb_address] = 1'b1;
    end

    // A bit being cleared this cycle is bypassed from writeback, so it never stalls.
    assign s_eff = s_pend & ~s_clr;
    assign v_eff = v_pend & ~v_clr;

    assign raw = (DE_src_used[0] & s_eff[DE_S1_address]) |
                 (DE_src_used[1] & s_eff[DE_S2_address]) |
                 (DE_src_used[2] & v_eff[DE_V1_address]) |
                 (DE_src_used[3] & v_eff[DE_V2_address]);
    assign waw = (DE_Swb_en & s_eff[DE_Swb_address]) |
                 (DE_Vwb_en & v_eff[DE_Vwb_address]);
    assign full = DE_long & (outstanding == MAX_CNT) & ~MEM_WB_long;

    assign DE_stall  = DE_issue & (raw | waw | full);
    assign DE_accept = DE_issue & ~DE_stall;
    assign set_go    = DE_accept & DE_long;
    assign dec       = MEM_WB_long & (outstanding != '0);

    always_comb begin
        s_set = '0;
        v_set = '0;
        if (set_go && DE_Swb_en) s_set[DE_Swb_address] = 1'b1;
        if (set_go && DE_Vwb_en) v_set[DE_Vwb_address] = 1'b1;
    end

    always_comb begin
        cnt_next = outstanding;
        if (set_go && !dec)      cnt_next = outstanding + CW'(1);
        else if (!set_go && dec) cnt_next = outstanding - CW'(1);
    end

    // Set is applied after clear so a same-cycle reissue to the same register wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_pend      <= '0;
            v_pend      <= '0;
            outstanding <= '0;
            sb_idle     <= 1'b1;
        end else begin
            s_pend      <= (s_pend & ~s_clr) | s_set;
            v_pend      <= (v_pend & ~v_clr) | v_set;
            outstanding <= cnt_next;
            sb_idle     <= (cnt_next == '0);
        end
    end

`ifdef WB_SCOREBOARD_CHECK_EN
    logic bad_clr, bad_under, bad_set;

    assign bad_clr   = MEM_WB_long & ((MEM_WB_Swb_en & ~s_pend[MEM_WB_Swb_address]) |
                                      (MEM_WB_Vwb_en & ~v_pend[MEM_WB_Vwb_address]));
    assign bad_under = MEM_WB_long & (outstanding == '0);
    assign bad_set   = set_go & (outstanding == MAX_CNT) & ~MEM_WB_long;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              sb_error <= 1'b0;
        else if (bad_clr | bad_under | bad_set) sb_error <= 1'b1;
    end

    a_no_bad_clr:   assert property (@(posedge clk) disable iff (rst) !bad_clr);
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !bad_under);
    a_no_over_set:  assert property (@(posedge clk) disable iff (rst) !bad_set);
`endif

endmodule

// File: tb/tb_wb_scoreboard.sv
// Scoreboard-style bench for wb_scoreboard: directed cycles push hand-computed
// expectations into a queue, and a negedge monitor pops and compares them.
module tb_wb_scoreboard;

    logic       clk;
    logic       rst;
    logic       DE_issue;
    logic [4:0] DE_S1_address, DE_S2_address;
    logic [3:0] DE_V1_address, DE_V2_address;
    logic [3:0] DE_src_used;
    logic       DE_Swb_en;
    logic [4:0] DE_Swb_address;
    logic       DE_Vwb_en;
    logic [3:0] DE_Vwb_address;
    logic       DE_long;
    logic       MEM_WB_long;
    logic       MEM_WB_Swb_en;
    logic [4:0] MEM_WB_Swb_address;
    logic       MEM_WB_Vwb_en;
    logic [3:0] MEM_WB_Vwb_address;
    logic       DE_stall;
    logic       DE_accept;
    logic [2:0] outstanding;
    logic       sb_idle;

    wb_scoreboard dut (
        .clk                (clk),
        .rst                (rst),
        .DE_issue           (DE_issue),
        .DE_S1_address      (DE_S1_address),
        .DE_S2_address      (DE_S2_address),
        .DE_V1_address      (DE_V1_address),
        .DE_V2_address      (DE_V2_address),
        .DE_src_used        (DE_src_used),
        .DE_Swb_en          (DE_Swb_en),
        .DE_Swb_address     (DE_Swb_address),
        .DE_Vwb_en          (DE_Vwb_en),
        .DE_Vwb_address     (DE_Vwb_address),
        .DE_long            (DE_long),
        .MEM_WB_long        (MEM_WB_long),
        .MEM_WB_Swb_en      (MEM_WB_Swb_en),
        .MEM_WB_Swb_address (MEM_WB_Swb_address),
        .MEM_WB_Vwb_en      (MEM_WB_Vwb_en),
        .MEM_WB_Vwb_address (MEM_WB_Vwb_address),
        .DE_stall           (DE_stall),
        .DE_accept          (DE_accept),
        .outstanding        (outstanding),
        .sb_idle            (sb_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int         id;
        logic       stall;
        logic       accept;
        logic [2:0] outs;
        logic       idle;
    } exp_t;

    exp_t exp_q[$];
    int   step_id = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        DE_issue           = 1'b0;
        DE_S1_address      = '0;
        DE_S2_address      = '0;
        DE_V1_address      = '0;
        DE_V2_address      = '0;
        DE_src_used        = '0;
        DE_Swb_en          = 1'b0;
        DE_Swb_address     = '0;
        DE_Vwb_en          = 1'b0;
        DE_Vwb_address     = '0;
        DE_long            = 1'b0;
        MEM_WB_long        = 1'b0;
        MEM_WB_Swb_en      = 1'b0;
        MEM_WB_Swb_address = '0;
        MEM_WB_Vwb_en      = 1'b0;
        MEM_WB_Vwb_address = '0;
    endtask

    task automatic apply_stimulus(input logic lng, input logic s_en, input logic [4:0] s_addr,
                                  input logic v_en, input logic [3:0] v_addr,
                                  input logic [3:0] src, input logic [4:0] s1, input logic [4:0] s2,
                                  input logic [3:0] v1, input logic [3:0] v2);
        DE_issue       = 1'b1;
        DE_long        = lng;
        DE_Swb_en      = s_en;
        DE_Swb_address = s_addr;
        DE_Vwb_en      = v_en;
        DE_Vwb_address = v_addr;
        DE_src_used    = src;
        DE_S1_address  = s1;
        DE_S2_address  = s2;
        DE_V1_address  = v1;
        DE_V2_address  = v2;
    endtask

    task automatic apply_writeback(input logic lng, input logic s_en, input logic [4:0] s_addr,
                                   input logic v_en, input logic [3:0] v_addr);
        MEM_WB_long        = lng;
        MEM_WB_Swb_en      = s_en;
        MEM_WB_Swb_address = s_addr;
        MEM_WB_Vwb_en      = v_en;
        MEM_WB_Vwb_address = v_addr;
    endtask

    task automatic check_output(input logic stall, input logic accept,
                                input logic [2:0] outs, input logic idle);
        exp_t e;
        step_id  = step_id + 1;
        e.id     = step_id;
        e.stall  = stall;
        e.accept = accept;
        e.outs   = outs;
        e.idle   = idle;
        exp_q.push_back(e);
    endtask

    task automatic compare(input string what, input int id,
                           input logic [2:0] act, input logic [2:0] want);
        n_checks = n_checks + 1;
        if (act === want) n_pass = n_pass + 1;
        else $display("[TB] FAIL step%0d %s: got %0d expected %0d", id, what, act, want);
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle away from the clock edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            compare("DE_stall",    e.id, {2'b0, DE_stall},  {2'b0, e.stall});
            compare("DE_accept",   e.id, {2'b0, DE_accept}, {2'b0, e.accept});
            compare("outstanding", e.id, outstanding,       e.outs);
            compare("sb_idle",     e.id, {2'b0, sb_idle},   {2'b0, e.idle});
        end
    end

    initial begin
        rst = 1'b1;
        tick();
        check_output(0, 0, 0, 1);

        // Reset mid-stream drops the pending S7.
        tick(); rst = 1'b0;
        apply_stimulus(1, 1, 7, 0, 0, 4'b0000, 0, 0, 0, 0);
        check_output(0, 1, 0, 1);
        tick(); apply_stimulus(0, 0, 0, 0, 0, 4'b0001, 7, 0, 0, 0);
        check_output(1, 0, 1, 0);
        tick(); rst = 1'b1;
        check_output(0, 0, 0, 1);
        tick(); rst = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 4'b0001, 7, 0, 0, 0);
        check_output(0, 1, 0, 1);

        // Long load to S5, RAW stall until the long writeback bypasses it.
        tick(); apply_stimulus(1, 1, 5, 0, 0, 4'b0000, 0, 0, 0, 0);
        check_output(0, 1, 0, 1);
        for (int i = 0; i < 2; i++) begin
            tick(); apply_stimulus(0, 1, 8, 0, 0, 4'b0001, 5, 0, 0, 0);
            check_output(1, 0, 1, 0);
        end
        tick(); apply_stimulus(0, 1, 8, 0, 0, 4'b0001, 5, 0, 0, 0);
        apply_writeback(1, 1, 5, 0, 0);
        check_output(0, 1, 1, 0);
        tick(); check_output(0, 0, 0, 1);

        // Vector WAW on V3; a non-long writeback must not clear it.
        tick(); apply_stimulus(1, 0, 0, 1, 3, 4'b0000, 0, 0, 0, 0);
        check_output(0, 1, 0, 1);
        tick(); apply_stimulus(0, 0, 0, 1, 3, 4'b0000, 0, 0, 0, 0);
        check_output(1, 0, 1, 0);
        tick(); apply_stimulus(0, 0, 0, 1, 3, 4'b0000, 0, 0, 0, 0);
        apply_writeback(0, 0, 0, 1, 3);
        check_output(1, 0, 1, 0);
        tick(); apply_stimulus(0, 0, 0, 1, 3, 4'b0000, 0, 0, 0, 0);
        check_output(1, 0, 1, 0);
        tick(); apply_writeback(1, 0, 0, 1, 3);
        check_output(0, 0, 1, 0);

        // Fill to four outstanding, FULL stall, then completion lets the fifth in.
        for (int i = 1; i <= 4; i++) begin
            tick(); apply_stimulus(1, 1, 5'(i), 0, 0, 4'b0000, 0, 0, 0, 0);
            check_output(0, 1, 3'(i - 1), (i == 1));
        end
        tick(); apply_stimulus(1, 1, 9, 0, 0, 4'b0000, 0, 0, 0, 0);
        check_output(1, 0, 4, 0);
        tick(); apply_stimulus(0, 0, 0, 0, 0, 4'b0001, 10, 0, 0, 0);
        check_output(0, 1, 4, 0);
        tick(); apply_stimulus(1, 1, 9, 0, 0, 4'b0000, 0, 0, 0, 0);
        apply_writeback(1, 1, 2, 0, 0);
        check_output(0, 1, 4, 0);
        tick(); apply_stimulus(0, 0, 0, 0, 0, 4'b0010, 0, 2, 0, 0);
        check_output(0, 1, 4, 0);
        tick(); apply_stimulus(0, 0, 0, 0, 0, 4'b0010, 0, 9, 0, 0);
        check_output(1, 0, 4, 0);

        // Drain two, then clear and reissue S6 in one cycle: set wins.
        tick(); apply_writeback(1, 1, 1, 0, 0);
        check_output(0, 0, 4, 0);
        tick(); apply_writeback(1, 1, 3, 0, 0);
        check_output(0, 0, 3, 0);
        tick(); apply_stimulus(1, 1, 6, 0, 0, 4'b0000, 0, 0, 0, 0);
        check_output(0, 1, 2, 0);
        tick(); apply_stimulus(1, 1, 6, 0, 0, 4'b0000, 0, 0, 0, 0);
        apply_writeback(1, 1, 6, 0, 0);
        check_output(0, 1, 3, 0);
        tick(); apply_stimulus(0, 0, 0, 0, 0, 4'b0001, 6, 0, 0, 0);
        check_output(1, 0, 3, 0);
        tick(); apply_writeback(1, 1, 6, 0, 0);
        check_output(0, 0, 3, 0);
        tick(); apply_writeback(1, 1, 4, 0, 0);
        check_output(0, 0, 2, 0);
        tick(); apply_writeback(1, 1, 9, 0, 0);
        check_output(0, 0, 1, 0);
        tick(); check_output(0, 0, 0, 1);

        // Long clear to a non-pending register at zero count: counter saturates.
        tick(); apply_writeback(1, 1, 12, 0, 0);
        check_output(0, 0, 0, 1);
        tick(); check_output(0, 0, 0, 1);

        // Vector RAW through the V2 source slot, released by bypass.
        tick(); apply_stimulus(1, 0, 0, 1, 5, 4'b0000, 0, 0, 0, 0);
        check_output(0, 1, 0, 1);
        tick(); apply_stimulus(0, 0, 0, 0, 0, 4'b1000, 0, 0, 0, 5);
        check_output(1, 0, 1, 0);
        tick(); apply_stimulus(0, 0, 0, 0, 0, 4'b1000, 0, 0, 0, 5);
        apply_writeback(1, 0, 0, 1, 5);
        check_output(0, 1, 1, 0);
        tick(); check_output(0, 0, 0, 1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks = n_checks + 1;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
